// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : battleship_pkg
//  Purpose  : Shared types, board limits, ship codes and big-bomb offsets.
//  Revision : 1.0
// ============================================================================
package battleship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PROBE  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam logic [3:0] BOARD_MIN = 4'd1;
  localparam logic [3:0] BOARD_MAX = 4'd10;

  localparam logic [4:0] PATROL     = 5'b00001;
  localparam logic [4:0] SUB        = 5'b00010;
  localparam logic [4:0] DESTROYER  = 5'b00100;
  localparam logic [4:0] BATTLESHIP = 5'b01000;
  localparam logic [4:0] CARRIER    = 5'b10000;

  // 3x3 walk: dy is the outer loop, dx the inner loop, both ascending.
  localparam logic signed [1:0] BIG_DX [0:8] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] BIG_DY [0:8] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

  function automatic logic [4:0] top_ship(input logic [4:0] acc);
    if (acc[4])      return CARRIER;
    else if (acc[3]) return BATTLESHIP;
    else if (acc[2]) return DESTROYER;
    else if (acc[1]) return SUB;
    else if (acc[0]) return PATROL;
    else             return 5'b00000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : key_edge_sync
//  Purpose  : Two-flop synchronizer plus edge register; pulses on a falling key.
//  Revision : 1.0
// ============================================================================
module key_edge_sync (
  input  logic clock,
  input  logic reset_N,
  input  logic key_L,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Reset to the released level so coming out of reset never fakes a press.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= key_L;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign pulse = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/bomb_turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_turn_sequencer
//  Purpose  : Validates a bomb request, probes 1 or 9 squares, commits results.
//  Revision : 1.0
// ============================================================================
module bomb_turn_sequencer #(
  parameter int BIG_BOMBS_INIT     = 2,
  parameter int TOTAL_SHIP_SQUARES = 19
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       scoreThis_L,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       big,
  output logic [3:0] probeX,
  output logic [3:0] probeY,
  input  logic       sqHit,
  input  logic       sqNearMiss,
  input  logic [4:0] sqShip,
  output logic       isHit,
  output logic       isNearMiss,
  output logic       isMiss,
  output logic [4:0] biggestShip,
  output logic [4:0] numberHit,
  output logic [1:0] bigLeft,
  output logic       somethingWrong,
  output logic       busy,
  output logic       gameOver
);
  import battleship_pkg::*;

  localparam logic [5:0] c_TOTAL    = 6'(TOTAL_SHIP_SQUARES);
  localparam logic [1:0] c_BIG_INIT = 2'(BIG_BOMBS_INIT);

  state_t r_state, w_state_next;
  logic [3:0]  r_cx, r_cy, r_slot;
  logic        r_big, r_any_hit, r_any_near;
  logic [4:0]  r_ship_acc, r_new_hits;
  logic [99:0] r_bombed;

  logic              w_pulse, w_req_ok, w_last_slot, w_in, w_reach_total;
  logic signed [1:0] w_dx, w_dy;
  logic signed [5:0] w_px, w_py;
  logic [6:0]        w_idx;
  logic [5:0]        w_sum;
  logic [4:0]        w_num_next;

  key_edge_sync u_key (
    .clock   (clock),
    .reset_N (reset_N),
    .key_L   (scoreThis_L),
    .pulse   (w_pulse)
  );

  assign w_req_ok = (X >= BOARD_MIN) && (X <= BOARD_MAX) &&
                    (Y >= BOARD_MIN) && (Y <= BOARD_MAX) &&
                    !(big && (bigLeft == 2'd0));

  always_comb begin
    w_dx = 2'sd0;
    w_dy = 2'sd0;
    if (r_big) begin
      w_dx = BIG_DX[r_slot];
      w_dy = BIG_DY[r_slot];
    end
  end

  assign w_px = $signed({2'b00, r_cx}) + $signed({{4{w_dx[1]}}, w_dx});
  assign w_py = $signed({2'b00, r_cy}) + $signed({{4{w_dy[1]}}, w_dy});
  assign w_in = (w_px >= $signed({2'b00, BOARD_MIN})) && (w_px <= $signed({2'b00, BOARD_MAX})) &&
                (w_py >= $signed({2'b00, BOARD_MIN})) && (w_py <= $signed({2'b00, BOARD_MAX}));

  // Off-board slots park the probe on the center and are ignored below.
  assign probeX = w_in ? w_px[3:0] : r_cx;
  assign probeY = w_in ? w_py[3:0] : r_cy;
  assign w_idx  = ({3'b000, probeY} - 7'd1) * 7'd10 + {3'b000, probeX} - 7'd1;

  assign w_last_slot   = (r_slot == (r_big ? 4'd8 : 4'd0));
  assign w_sum         = {1'b0, numberHit} + {1'b0, r_new_hits};
  assign w_num_next    = (w_sum >= c_TOTAL) ? c_TOTAL[4:0] : w_sum[4:0];
  assign w_reach_total = ({1'b0, w_num_next} == c_TOTAL);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_pulse && w_req_ok) w_state_next = ST_PROBE;
      ST_PROBE:  if (w_last_slot) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = w_reach_total ? ST_OVER : ST_IDLE;
      ST_OVER:   w_state_next = ST_OVER;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_cx <= '0; r_cy <= '0; r_slot <= '0; r_big <= 1'b0;
      r_any_hit <= 1'b0; r_any_near <= 1'b0; r_ship_acc <= '0; r_new_hits <= '0;
      r_bombed <= '0;
      isHit <= 1'b0; isNearMiss <= 1'b0; isMiss <= 1'b0;
      biggestShip <= '0; numberHit <= '0; bigLeft <= c_BIG_INIT;
      somethingWrong <= 1'b0; busy <= 1'b0; gameOver <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pulse) begin
          if (w_req_ok) begin
            somethingWrong <= 1'b0;
            busy           <= 1'b1;
            r_cx <= X; r_cy <= Y; r_big <= big; r_slot <= '0;
            r_any_hit <= 1'b0; r_any_near <= 1'b0; r_ship_acc <= '0; r_new_hits <= '0;
          end else begin
            somethingWrong <= 1'b1;
          end
        end
        ST_PROBE: begin
          if (w_in) begin
            r_any_hit  <= r_any_hit | sqHit;
            r_any_near <= r_any_near | sqNearMiss;
            r_ship_acc <= r_ship_acc | sqShip;
            if (sqHit && !r_bombed[w_idx]) begin
              r_new_hits      <= r_new_hits + 5'd1;
              r_bombed[w_idx] <= 1'b1;
            end
          end
          if (!w_last_slot) r_slot <= r_slot + 4'd1;
        end
        ST_COMMIT: begin
          isHit       <= r_any_hit;
          isNearMiss  <= !r_any_hit && r_any_near;
          isMiss      <= !r_any_hit && !r_any_near;
          biggestShip <= top_ship(r_ship_acc);
          numberHit   <= w_num_next;
          if (r_big) bigLeft <= bigLeft - 2'd1;
          busy     <= 1'b0;
          gameOver <= w_reach_total;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
